apb_matmul_requester: RTL and testbench
=======================================

APB_MATMUL_REQUESTER -- requirements
Module: apb_matmul_requester

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 16: maximum ACCESS-phase cycles waited for PREADY before abort.
REQ-002 SHALL have parameter POLL_MAX, default 1024: maximum DONE-register reads before abort.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid / cmd_ready, input / output, 1 each: job handshake.
REQ-006 SHALL have ports cmd_addr_a, cmd_addr_b, cmd_addr_c, input, 10 each: matrix base addresses.
REQ-007 SHALL have ports cmd_stride_a, cmd_stride_b, cmd_stride_c, input, 8 each: address strides.
REQ-008 SHALL have ports PSEL, PENABLE, PWRITE, output, 1 each: APB requester controls.
REQ-009 SHALL have ports PADDR (output, 4), PWDATA (output, 16), PRDATA (input, 16) and PREADY (input, 1): APB address, data and ready.
REQ-010 SHALL have ports busy (output, 1), done (output, 1-cycle pulse), err (output, 1-cycle pulse) and err_code (output, 2): status; err_code 01 = PREADY timeout, 10 = poll limit.

Function
REQ-011 SHALL assert cmd_ready only when the sequencer is in S_IDLE; on cmd_valid&&cmd_ready it SHALL latch all six cmd fields and set busy the next cycle.
REQ-012 SHALL issue the job as nine transfers in this fixed order:
- writes: 0x2=addr_a, 0x3=addr_b, 0x4=addr_c, 0x5=stride_a, 0x6=stride_b, 0x7=stride_c, 0x0=0x0001 (start);
- poll reads of 0x1;
- final write 0x0=0x0000 (start clear).
REQ-013 SHALL zero-extend write data to 16 bits on PWDATA.
REQ-014 Each transfer SHALL follow this cycle-level sequence:
- SETUP cycle: PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA valid.
- ACCESS: PSEL=1, PENABLE=1, with PADDR/PWRITE/PWDATA held stable until PREADY is sampled 1.
- Then at least one cycle with PSEL=0, PENABLE=0.
REQ-015 SHALL treat a read of 0x1 as complete when PREADY=1 and PRDATA[15]=1; PRDATA is sampled only in the cycle PREADY=1.
REQ-016 If PRDATA[15]=0, SHALL issue another read of 0x1 after the mandatory idle cycle, counting reads.
REQ-017 SHALL, after done is observed, perform the start-clear write, then pulse done for one cycle, clear busy and return to S_IDLE.
REQ-018 SHALL abort with err_code=01 if PREADY stays 0 for WAIT_MAX consecutive ACCESS cycles:
- drop PSEL/PENABLE the next cycle;
- pulse err for one cycle;
- return to S_IDLE with no start-clear write.
REQ-019 SHALL abort with err_code=10 when POLL_MAX reads return PRDATA[15]=0:
- perform the start-clear write;
- pulse err;
- return to S_IDLE.
REQ-020 SHALL use sequencer states S_IDLE, S_CFG (writes 0x2..0x7), S_START, S_POLL, S_CLEAR, S_FIN.
REQ-021 SHALL use APB engine states IDLE, SETUP, ACCESS.
REQ-022 SHALL never assert PENABLE without PSEL, and never change PADDR while PSEL=1.
REQ-023 SHALL ignore cmd_valid while busy; cmd fields SHALL NOT affect an in-flight job.
REQ-024 SHALL hold err_code until the next accepted command, then clear it to 00.
REQ-025 The poll counter SHALL saturate at POLL_MAX and SHALL NOT wrap.
REQ-026 The wait counter SHALL reset at every SETUP cycle.

Reset
REQ-027 While reset=1, SHALL asynchronously drive PSEL, PENABLE, PWRITE, busy, done, err = 0; PADDR, PWDATA, err_code = 0; cmd_ready = 0; both FSMs to IDLE; counters to 0.
REQ-028 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately, without waiting for a clock edge.
REQ-029 cmd_ready SHALL assert in the first clock cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold:
- register address constants for START 0x0, DONE 0x1, ADDR_A/B/C 0x2–0x4, STRIDE_A/B/C 0x5–0x7;
- the DONE bit index 15;
- address width 10 and stride width 8;
- the err_code enum.
REQ-031 The single-transfer engine SHALL be a sub-module apb_xfer_engine with interface: req/addr/wr/wdata in; ack/rdata/timeout out.
REQ-032 The RTL target SHALL be 150–350 lines total.

Verification
REQ-033 Stimulus: job a=0x010, b=0x020, c=0x030, strides 4/4/4, completer with 2-cycle PREADY latency, done after 3 polls.
- Required: write sequence 2,3,4,5,6,7,0 with data 0x0010,0x0020,0x0030,0x0004,0x0004,0x0004,0x0001.
- Required: three reads of 0x1, then write 0x0=0x0000, then one done pulse.
REQ-034 Stimulus: PREADY held 0 during the first write.
- Required: PSEL drops after 16 ACCESS cycles, err pulses with err_code=01, busy=0, no further transfers.
REQ-035 Stimulus: DONE never set, POLL_MAX=8.
- Required: exactly 8 reads, then the start-clear write, then err with err_code=10.
REQ-036 Stimulus: reset asserted during the ACCESS phase of the 0x5 write.
- Required: PSEL=0 in the same cycle.
- Required: a new job after release starts again at 0x2.
REQ-037 Stimulus: cmd_valid pulsed with different fields while busy.
- Required: ignored; the running job's PWDATA is unchanged.
- Required: assertion check holds that PADDR is stable throughout PSEL=1 and there is at least one idle cycle between transfers.

Source files
------------

// File: rtl/apb_matmul_requester_pkg.sv
// apb_matmul_requester_pkg: register map, field widths and state/status encodings
// shared by the matmul APB requester and its transfer engine.
package apb_matmul_requester_pkg;
    localparam logic [3:0] REG_START    = 4'h0;
    localparam logic [3:0] REG_DONE     = 4'h1;
    localparam logic [3:0] REG_ADDR_A   = 4'h2;
    localparam logic [3:0] REG_ADDR_B   = 4'h3;
    localparam logic [3:0] REG_ADDR_C   = 4'h4;
    localparam logic [3:0] REG_STRIDE_A = 4'h5;
    localparam logic [3:0] REG_STRIDE_B = 4'h6;
    localparam logic [3:0] REG_STRIDE_C = 4'h7;
    localparam int DONE_BIT = 15;
    localparam logic [15:0] DONE_MASK = 16'h0001 << DONE_BIT;
    localparam int ADDR_W = 10;
    localparam int STRIDE_W = 8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_POLL    = 2'b10
    } err_code_e;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_POLL, S_CLEAR, S_FIN} seq_state_e;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/apb_matmul_requester_xfer.sv
// apb_xfer_engine: runs one APB transfer (SETUP then ACCESS) per req pulse,
// returning ack with read data, or timeout after WAIT_MAX stalled ACCESS cycles.
module apb_xfer_engine
    import apb_matmul_requester_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [3:0]  addr_i,
    input  logic        wr_i,
    input  logic [15:0] wdata_i,
    output logic        ack_o,
    output logic [15:0] rdata_o,
    output logic        timeout_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [3:0]  paddr_o,
    output logic [15:0] pwdata_o,
    input  logic        pready_i,
    input  logic [15:0] prdata_i
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    apb_state_e  state_q;
    logic [WW-1:0] wait_q;
    logic        ack_q, timeout_q, psel_q, penable_q, pwrite_q;
    logic [3:0]  paddr_q;
    logic [15:0] pwdata_q, rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: if (req_i) begin
                    state_q  <= SETUP;
                    psel_q   <= 1'b1;
                    paddr_q  <= addr_i;
                    pwrite_q <= wr_i;
                    pwdata_q <= wdata_i;
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                end
                ACCESS: if (pready_i) begin
                    state_q   <= IDLE;
                    ack_q     <= 1'b1;
                    rdata_q   <= prdata_i;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end else if (wait_q == WW'(WAIT_MAX - 1)) begin
                    state_q   <= IDLE;
                    timeout_q <= 1'b1;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end else begin
                    wait_q <= wait_q + WW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign timeout_o = timeout_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
endmodule

// File: rtl/apb_matmul_requester.sv
// apb_matmul_requester: programs a matmul accelerator over APB (config writes,
// start, DONE polling, start clear) and reports done or a coded error.
module apb_matmul_requester
    import apb_matmul_requester_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int POLL_MAX = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr_a,
    input  logic [ADDR_W-1:0]   cmd_addr_b,
    input  logic [ADDR_W-1:0]   cmd_addr_c,
    input  logic [STRIDE_W-1:0] cmd_stride_a,
    input  logic [STRIDE_W-1:0] cmd_stride_b,
    input  logic [STRIDE_W-1:0] cmd_stride_c,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [3:0]          PADDR,
    output logic [15:0]         PWDATA,
    input  logic [15:0]         PRDATA,
    input  logic                PREADY,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    localparam int PW = $clog2(POLL_MAX + 1);

    seq_state_e          state_q;
    err_code_e           err_code_q;
    logic                cmd_ready_q, busy_q, done_q, err_q, req_q, wr_q, poll_err_q;
    logic [3:0]          addr_q;
    logic [15:0]         wdata_q;
    logic [2:0]          idx_q;
    logic [PW-1:0]       poll_q;
    logic [ADDR_W-1:0]   b_q, c_q;
    logic [STRIDE_W-1:0] sa_q, sb_q, sc_q;
    logic                ack, timeout, done_seen;
    logic [15:0]         rdata, cfg_nxt;
    logic [2:0]          nxt;

    // Config writes 0x2..0x7 are indexed 0..5; the first is issued straight from the command.
    assign nxt       = idx_q + 3'd1;
    assign cfg_nxt   = nxt == 3'd1 ? 16'(b_q) : nxt == 3'd2 ? 16'(c_q) :
                       nxt == 3'd3 ? 16'(sa_q) : nxt == 3'd4 ? 16'(sb_q) : 16'(sc_q);
    assign done_seen = |(rdata & DONE_MASK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            err_code_q  <= ERR_NONE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            poll_err_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
            poll_q      <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            sc_q        <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            req_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                cmd_ready_q <= 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    b_q         <= cmd_addr_b;
                    c_q         <= cmd_addr_c;
                    sa_q        <= cmd_stride_a;
                    sb_q        <= cmd_stride_b;
                    sc_q        <= cmd_stride_c;
                    err_code_q  <= ERR_NONE;
                    busy_q      <= 1'b1;
                    cmd_ready_q <= 1'b0;
                    state_q     <= S_CFG;
                    idx_q       <= '0;
                    poll_q      <= '0;
                    poll_err_q  <= 1'b0;
                    req_q       <= 1'b1;
                    addr_q      <= REG_ADDR_A;
                    wr_q        <= 1'b1;
                    wdata_q     <= 16'(cmd_addr_a);
                end
            end else if (state_q == S_FIN) begin
                done_q      <= !poll_err_q;
                err_q       <= poll_err_q;
                err_code_q  <= poll_err_q ? ERR_POLL : err_code_q;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
                state_q     <= S_IDLE;
            end else if (timeout) begin
                err_q       <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
                state_q     <= S_IDLE;
            end else if (ack) begin
                req_q   <= 1'b1;
                wr_q    <= 1'b1;
                addr_q  <= REG_START;
                wdata_q <= '0;
                case (state_q)
                    S_CFG: if (idx_q == 3'd5) begin
                        state_q <= S_START;
                        wdata_q <= 16'h0001;
                    end else begin
                        idx_q   <= nxt;
                        addr_q  <= REG_ADDR_A + {1'b0, nxt};
                        wdata_q <= cfg_nxt;
                    end
                    S_START: begin
                        state_q <= S_POLL;
                        addr_q  <= REG_DONE;
                        wr_q    <= 1'b0;
                    end
                    S_POLL: begin
                        poll_q <= poll_q == PW'(POLL_MAX) ? poll_q : poll_q + PW'(1);
                        if (done_seen) begin
                            state_q <= S_CLEAR;
                        end else if (poll_q >= PW'(POLL_MAX - 1)) begin
                            state_q    <= S_CLEAR;
                            poll_err_q <= 1'b1;
                        end else begin
                            addr_q <= REG_DONE;
                            wr_q   <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        state_q <= S_FIN;
                        req_q   <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    apb_xfer_engine #(.WAIT_MAX(WAIT_MAX)) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_q),
        .addr_i    (addr_q),
        .wr_i      (wr_q),
        .wdata_i   (wdata_q),
        .ack_o     (ack),
        .rdata_o   (rdata),
        .timeout_o (timeout),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .paddr_o   (PADDR),
        .pwdata_o  (PWDATA),
        .pready_i  (PREADY),
        .prdata_i  (PRDATA)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
endmodule

// File: tb/tb_apb_matmul_requester.sv
// tb_apb_matmul_requester: randomized jobs against a scripted APB completer; a
// scoreboard of expected transfers and outcomes is checked by a separate monitor.
module tb_apb_matmul_requester;
    localparam int WM = 16;
    localparam int PM = 8;

    typedef struct {
        logic        wr;
        logic [3:0]  a;
        logic [15:0] d;
    } xfer_t;

    logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  ca = '0, cb = '0, cc = '0;
    logic [7:0]  csa = '0, csb = '0, csc = '0;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [3:0]  PADDR;
    logic [15:0] PWDATA, PRDATA;
    logic        busy, done, err;
    logic [1:0]  err_code;

    xfer_t exp_q[$];
    int    out_q[$];
    int    total = 0, bad = 0;
    int    need_polls = 1, lat_c = 0, reads_done = 0, acc_n = 0;
    bit    hang = 1'b0, fin_read = 1'b0;

    apb_matmul_requester #(.WAIT_MAX(WM), .POLL_MAX(PM)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr_a(ca), .cmd_addr_b(cb), .cmd_addr_c(cc),
        .cmd_stride_a(csa), .cmd_stride_b(csb), .cmd_stride_c(csc),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Completer: PREADY after lat_c+1 ACCESS cycles; DONE bit set on the need_polls-th read.
    initial begin
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fin_read) reads_done++;
            acc_n    = (PSEL && PENABLE) ? acc_n + 1 : 0;
            PREADY   = PSEL && PENABLE && !hang && acc_n > lat_c;
            PRDATA   = {reads_done + 1 >= need_polls, 15'($urandom)};
            fin_read = PREADY && !PWRITE && PADDR == 4'h1;
        end
    end

    // Monitor: protocol checks plus scoreboard pops on transfer completion and on done/err.
    initial begin
        logic        prev_psel = 1'b0;
        logic [3:0]  prev_addr = '0;
        logic [15:0] prev_wd = '0;
        int          acc_run = 0, acc_last = 0, o;
        xfer_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_psel = 1'b0;
                acc_run = 0;
            end else begin
                if (PENABLE) chk("penable_needs_psel", PSEL, 1);
                if (PSEL && prev_psel) begin
                    chk("paddr_stable", PADDR, prev_addr);
                    chk("pwdata_stable", PWDATA, prev_wd);
                end
                if (PSEL && !PENABLE) chk("idle_before_setup", prev_psel, 0);
                if (PSEL && PENABLE) acc_run++;
                else begin
                    if (acc_run != 0) acc_last = acc_run;
                    acc_run = 0;
                end
                if (PSEL && PENABLE && PREADY) begin
                    chk("xfer_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("xfer_wr", PWRITE, e.wr);
                        chk("xfer_addr", PADDR, e.a);
                        if (e.wr) chk("xfer_data", PWDATA, e.d);
                    end
                end
                if (done || err) begin
                    chk("outcome_expected", out_q.size() != 0, 1);
                    if (out_q.size() != 0) begin
                        o = out_q.pop_front();
                        chk("done_pulse", done, o == 0);
                        chk("err_pulse", err, o != 0);
                        chk("err_code", err_code, o);
                        chk("busy_at_end", busy, 0);
                        chk("xfers_drained", exp_q.size(), 0);
                        if (o == 1) chk("timeout_access_cycles", acc_last, WM);
                    end
                end
                prev_psel = PSEL;
                prev_addr = PADDR;
                prev_wd   = PWDATA;
            end
        end
    end

    // Reference model: a job is six config writes, start, DONE reads up to the poll limit, clear.
    task automatic issue(input logic [9:0] a, b, c, input logic [7:0] sa, sb, sc,
                         input int need, input int lat, input bit h);
        logic [15:0] v[6];
        int n = 0, reads;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        v = '{16'(a), 16'(b), 16'(c), 16'(sa), 16'(sb), 16'(sc)};
        if (h) out_q.push_back(1);
        else begin
            for (int i = 0; i < 6; i++) exp_q.push_back('{wr: 1'b1, a: 4'(2 + i), d: v[i]});
            exp_q.push_back('{wr: 1'b1, a: 4'h0, d: 16'h0001});
            reads = need <= PM ? need : PM;
            for (int i = 0; i < reads; i++) exp_q.push_back('{wr: 1'b0, a: 4'h1, d: 16'h0});
            exp_q.push_back('{wr: 1'b1, a: 4'h0, d: 16'h0000});
            out_q.push_back(need <= PM ? 0 : 2);
        end
        reads_done = 0;
        need_polls = need;
        lat_c = lat;
        hang = h;
        {ca, cb, cc, csa, csb, csc} = {a, b, c, sa, sb, sc};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_low_busy", cmd_ready, 0);
    endtask

    task automatic finish_job();
        int n = 0;
        while (out_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("job_outcome_seen", out_q.size(), 0);
        @(negedge clk);
        chk("idle_after_job", {busy, cmd_ready}, 2'b01);
        hang = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        chk("rst_status", {busy, done, err, err_code, cmd_ready}, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        issue(10'h010, 10'h020, 10'h030, 8'd4, 8'd4, 8'd4, 3, 2, 1'b0);
        finish_job();
        issue(10'h3ff, 10'h155, 10'h2aa, 8'hff, 8'h01, 8'h80, 2, 0, 1'b1);
        finish_job();
        issue(10'h001, 10'h002, 10'h003, 8'd5, 8'd6, 8'd7, 100, 1, 1'b0);
        finish_job();

        // Command offered mid-job must be ignored.
        issue(10'h123, 10'h234, 10'h345, 8'h11, 8'h22, 8'h33, 2, 1, 1'b0);
        repeat (6) @(negedge clk);
        {ca, cb, cc, csa, csb, csc} = {10'h3ff, 10'h3ff, 10'h3ff, 8'hee, 8'hee, 8'hee};
        cmd_valid = 1'b1;
        chk("cmd_ready_while_busy", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        finish_job();

        // Reset during the ACCESS phase of the stride_a write.
        issue(10'h050, 10'h060, 10'h070, 8'd1, 8'd2, 8'd3, 1, 3, 1'b0);
        n = 0;
        while (!(PSEL && PENABLE && PADDR == 4'h5) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reached_stride_a_access", {PSEL, PENABLE, PADDR}, {2'b11, 4'h5});
        #2 reset = 1'b1;
        #1 chk("async_reset_drops_apb", {PSEL, PENABLE}, 0);
        exp_q.delete();
        out_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(10'h0a0, 10'h0b0, 10'h0c0, 8'd9, 8'd8, 8'd7, 2, 0, 1'b0);
        n = 0;
        while (!PSEL && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("restart_at_addr_a", {PSEL, PADDR}, {1'b1, 4'h2});
        finish_job();

        for (int j = 0; j < 8; j++) begin
            issue(10'($urandom), 10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), $urandom_range(1, 10), $urandom_range(0, 3), 1'b0);
            finish_job();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
